// File: rtl/uart8_pkg.sv
// Shared definitions for the UART transmit queue: FSM encodings and synchronizer depth.
package uart8_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } uart8_state_e;

endpackage

// File: rtl/uart8_sync2.sv
// Multi-flop synchronizer bringing a txClk-domain level into the board clock domain.
module uart8_sync2
    import uart8_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart8_tx_queue.sv
// Byte FIFO plus start/busy handshake sequencer feeding a slow-clock UART transmitter.
// Optional statistics outputs (sentCount, dropSticky) when UART8_TXQ_STATS_EN is defined.
module uart8_tx_queue
    import uart8_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              wrEn,
    input  logic [7:0]        wrData,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              idle,
    output logic              txStart,
    output logic [7:0]        txIn,
    input  logic              txBusy,
    input  logic              txDone
`ifdef UART8_TXQ_STATS_EN
    ,
    output logic [15:0]       sentCount,
    output logic              dropSticky
`endif
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [7:0]        r_tx_in;
    logic              r_overflow;
    uart8_state_e      r_state;
    uart8_state_e      w_next_state;
    logic              w_tx_start;
    logic              w_push;
    logic              w_pop;
    logic              w_busy_s;
    logic              w_done_s;

    // Busy syncs to 1 so after any reset the FSM waits for a live low before launching.
    uart8_sync2 #(.RST_VAL(1'b1)) u_sync_busy (
        .clk  (clk),
        .rstN (rstN),
        .d    (txBusy),
        .q    (w_busy_s)
    );

    uart8_sync2 #(.RST_VAL(1'b0)) u_sync_done (
        .clk  (clk),
        .rstN (rstN),
        .d    (txDone),
        .q    (w_done_s)
    );

    assign full   = (r_level == L_DEPTH);
    assign empty  = (r_level == '0);
    assign w_push = wrEn && !full;
    assign w_pop  = (r_state == ST_LOAD) && !empty;

    // NOTE: the byte array has no reset; occupancy is tracked by the pointers and level only.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_tx_in    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_overflow <= wrEn && full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_tx_in  <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_tx_start   = 1'b0;
        case (r_state)
            ST_IDLE:  if (!empty && !w_busy_s) w_next_state = ST_LOAD;
            ST_LOAD:  w_next_state = ST_START;
            ST_START: begin
                w_tx_start = 1'b1;
                if (w_busy_s) w_next_state = ST_WAIT;
            end
            ST_WAIT:  if (!w_busy_s || w_done_s) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    assign level    = r_level;
    assign overflow = r_overflow;
    assign txStart  = w_tx_start;
    assign txIn     = r_tx_in;
    assign idle     = empty && (r_state == ST_IDLE) && !w_busy_s;

`ifdef UART8_TXQ_STATS_EN
    logic        w_frame_done;
    logic [15:0] r_sent_count;
    logic        r_drop_sticky;

    assign w_frame_done = (r_state == ST_WAIT) && (w_next_state == ST_IDLE);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_sent_count  <= '0;
            r_drop_sticky <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_sent_count <= r_sent_count + 16'd1;
            end
            if (wrEn && full) begin
                r_drop_sticky <= 1'b1;
            end
        end
    end

    assign sentCount  = r_sent_count;
    assign dropSticky = r_drop_sticky;
`endif

endmodule

// File: tb/tb_uart8_tx_queue.sv
// Self-checking bench for uart8_tx_queue with a slow-clock transmitter model and a frame log.
module tb_uart8_tx_queue;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rstN;
    logic       wrEn;
    logic [7:0] wrData;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       idle;
    logic       txStart;
    logic [7:0] txIn;
`ifdef UART8_TXQ_STATS_EN
    logic [15:0] sentCount;
    logic        dropSticky;
`endif

    logic       tx_clk;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_stall;
    int         bits_left;
    logic [7:0] shreg;
    logic [7:0] tx_log[$];

    int         n_checks;
    int         n_pass;
    int         hold_err;
    logic       prev_start;
    logic [7:0] prev_in;

    uart8_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .wrEn     (wrEn),
        .wrData   (wrData),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .idle     (idle),
        .txStart  (txStart),
        .txIn     (txIn),
        .txBusy   (tx_busy),
        .txDone   (tx_done)
`ifdef UART8_TXQ_STATS_EN
        ,
        .sentCount  (sentCount),
        .dropSticky (dropSticky)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter clock 16x slower, offset so its edges never coincide with clk edges.
    initial begin
        tx_clk = 1'b0;
        #3;
        forever #80 tx_clk = ~tx_clk;
    end

    // Transmitter model: a frame is 10 bit-times; the byte is logged when the frame ends.
    always @(posedge tx_clk) begin
        tx_done <= 1'b0;
        if (bits_left != 0) begin
            bits_left <= bits_left - 1;
            if (bits_left == 1) begin
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
                tx_log.push_back(shreg);
            end
        end else if (tx_stall) begin
            tx_busy <= 1'b1;
        end else if (txStart) begin
            tx_busy   <= 1'b1;
            shreg     <= txIn;
            bits_left <= 10;
        end else begin
            tx_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rstN && txStart && prev_start && (txIn !== prev_in)) begin
            hold_err <= hold_err + 1;
        end
        prev_start <= txStart;
        prev_in    <= txIn;
    end

    task automatic push_byte(input logic [7:0] b);
        wrEn   = 1'b1;
        wrData = b;
        @(negedge clk);
        wrEn   = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int cyc = 0;
        while (tx_log.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (tx_log.size() < n)
            $display("FAIL %s: frames=%0d expected %0d within %0d cycles", name, tx_log.size(), n, budget);
        else
            n_pass++;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int cyc = 0;
        while (!idle && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (idle !== 1'b1)
            $display("FAIL %s: idle=%b expected 1 within %0d cycles", name, idle, budget);
        else
            n_pass++;
    endtask

    task automatic compare_log(input logic [7:0] exp_q[$], input string name);
        logic [7:0] got;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
            n_checks++;
            if (got !== exp_q[i])
                $display("FAIL %s[%0d]: sent=%02h expected %02h", name, i, got, exp_q[i]);
            else
                n_pass++;
        end
        n_checks++;
        if (tx_log.size() != exp_q.size())
            $display("FAIL %s_count: frames=%0d expected %0d", name, tx_log.size(), exp_q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        int cyc;
        rstN = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({full, empty, level, overflow, txStart, txIn, idle} !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0})
            $display("FAIL reset_values: full=%b empty=%b level=%0d ovf=%b start=%b txIn=%02h idle=%b expected 0 1 0 0 0 00 0",
                     full, empty, level, overflow, txStart, txIn, idle);
        else
            n_pass++;
        rstN = 1'b1;
        cyc = 0;
        while (!idle && cyc < 3) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (idle !== 1'b1)
            $display("FAIL reset_idle: idle=%b expected 1 within 3 clk", idle);
        else
            n_pass++;
    endtask

    task automatic test_single();
        logic [7:0] exp_q[$];
        int cyc;
        tx_log.delete();
        wrEn   = 1'b1;
        wrData = 8'h55;
        @(negedge clk);
        wrEn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (txStart !== 1'b0)
            $display("FAIL latency_n1: txStart=%b expected 0", txStart);
        else
            n_pass++;
        @(negedge clk);
        n_checks++;
        if (txStart !== 1'b1 || txIn !== 8'h55)
            $display("FAIL latency_n2: txStart=%b txIn=%02h expected 1 55", txStart, txIn);
        else
            n_pass++;
        cyc = 0;
        while (txStart && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (txStart !== 1'b0 || tx_busy !== 1'b1)
            $display("FAIL start_release: txStart=%b busy=%b expected 0 1", txStart, tx_busy);
        else
            n_pass++;
        wait_log(1, 400, "single_frame");
        wait_idle(50, "single_idle");
        exp_q.push_back(8'h55);
        compare_log(exp_q, "single");
    endtask

    task automatic test_full_overflow();
        logic [7:0] exp_q[$];
        tx_log.delete();
        tx_stall = 1'b1;
        repeat (40) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            push_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        n_checks++;
        if (full !== 1'b1 || level !== 5'd16 || empty !== 1'b0)
            $display("FAIL burst_full: full=%b level=%0d empty=%b expected 1 16 0", full, level, empty);
        else
            n_pass++;
        push_byte(8'hAA);
        n_checks++;
        if (overflow !== 1'b1 || level !== 5'd16)
            $display("FAIL overflow_pulse: overflow=%b level=%0d expected 1 16", overflow, level);
        else
            n_pass++;
        @(negedge clk);
        n_checks++;
        if (overflow !== 1'b0)
            $display("FAIL overflow_width: overflow=%b expected 0", overflow);
        else
            n_pass++;
        tx_stall = 1'b0;
        wait_log(DEPTH, 400 * DEPTH, "burst_frames");
        wait_idle(400, "burst_idle");
        repeat (400) @(negedge clk);
        n_checks++;
        if (empty !== 1'b1 || level !== 5'd0)
            $display("FAIL burst_empty: empty=%b level=%0d expected 1 0", empty, level);
        else
            n_pass++;
        compare_log(exp_q, "burst");
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int n;
        tx_log.delete();
        n = $urandom_range(4, DEPTH);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            push_byte(b);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 300)) @(negedge clk);
        end
        wait_log(n, 400 * n, "random_frames");
        wait_idle(400, "random_idle");
        compare_log(exp_q, "random");
        n_checks++;
        if (hold_err !== 0)
            $display("FAIL txin_hold: changes=%0d expected 0", hold_err);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b[5];
        logic [7:0] exp_q[$];
        logic [7:0] nb;
        int cyc;
        int viol;
        tx_log.delete();
        for (int i = 0; i < 5; i++) begin
            b[i] = 8'($urandom);
            push_byte(b[i]);
        end
        cyc = 0;
        while (!(tx_log.size() >= 2 && tx_busy) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (!(tx_log.size() >= 2 && tx_busy))
            $display("FAIL third_frame: frames=%0d busy=%b expected 2 1", tx_log.size(), tx_busy);
        else
            n_pass++;
        repeat ($urandom_range(1, 40)) @(negedge clk);
        rstN = 1'b0;
        #1;
        n_checks++;
        if (txStart !== 1'b0 || empty !== 1'b1 || level !== 5'd0)
            $display("FAIL midreset_clear: txStart=%b empty=%b level=%0d expected 0 1 0", txStart, empty, level);
        else
            n_pass++;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        nb = 8'($urandom);
        push_byte(nb);
        viol = 0;
        cyc  = 0;
        while (tx_busy && cyc < 1000) begin
            if (txStart) viol++;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (viol != 0 || tx_busy !== 1'b0)
            $display("FAIL midreset_hold: starts_while_busy=%0d busy=%b expected 0 0", viol, tx_busy);
        else
            n_pass++;
        wait_log(4, 1000, "midreset_frames");
        wait_idle(400, "midreset_idle");
        exp_q.push_back(b[0]);
        exp_q.push_back(b[1]);
        exp_q.push_back(b[2]);
        exp_q.push_back(nb);
        compare_log(exp_q, "midreset");
    endtask

`ifdef UART8_TXQ_STATS_EN
    task automatic test_stats();
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        tx_log.delete();
        wait_idle(10, "stats_idle");
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        wait_log(5, 2000, "stats_frames");
        wait_idle(400, "stats_idle2");
        n_checks++;
        if (sentCount !== 16'(tx_log.size()) || dropSticky !== 1'b0)
            $display("FAIL stats_sent: sentCount=%0d drop=%b expected %0d 0", sentCount, dropSticky, tx_log.size());
        else
            n_pass++;
        tx_stall = 1'b1;
        repeat (40) @(negedge clk);
        for (int i = 0; i <= DEPTH; i++) push_byte(8'($urandom));
        repeat (5) @(negedge clk);
        n_checks++;
        if (sentCount !== 16'd5 || dropSticky !== 1'b1)
            $display("FAIL stats_drop: sentCount=%0d drop=%b expected 5 1", sentCount, dropSticky);
        else
            n_pass++;
        tx_stall = 1'b0;
        wait_log(5 + DEPTH, 400 * DEPTH, "stats_drain");
        wait_idle(400, "stats_idle3");
        n_checks++;
        if (sentCount !== 16'(tx_log.size()) || dropSticky !== 1'b1)
            $display("FAIL stats_final: sentCount=%0d drop=%b expected %0d 1", sentCount, dropSticky, tx_log.size());
        else
            n_pass++;
    endtask
`endif

    initial begin
        rstN       = 1'b0;
        wrEn       = 1'b0;
        wrData     = 8'h00;
        tx_stall   = 1'b0;
        tx_busy    = 1'b0;
        tx_done    = 1'b0;
        bits_left  = 0;
        shreg      = 8'h00;
        n_checks   = 0;
        n_pass     = 0;
        hold_err   = 0;
        prev_start = 1'b0;
        prev_in    = 8'h00;
        test_reset();
        test_single();
        test_full_overflow();
        test_random();
        test_reset_mid_frame();
`ifdef UART8_TXQ_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
